mem_arbiter: RTL and testbench

Shares the single 16-bit main memory port between the CPU datapath's memory cycles (MI/RI/RO traffic) and a DMA/boot-loader requester. It sequences each access through a fixed number of memory wait states and stalls the CPU's T-state counter while the CPU's access is pending. The arbiter gives the CPU fixed priority, with an optional starvation guard for DMA. It sits between the CPU and the RAM, and it is the only block that drives the memory port.

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the shared 16-bit memory port between the CPU and a DMA requester.
// Define MEM_ARB_STARVE_GUARD_EN to force DMA through after STARVE_LIMIT CPU grants.
module mem_arbiter #(
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

    localparam logic [2:0] WS_LAST = WAIT_STATES[2:0];

    state_t     state;
    logic [2:0] cnt;
    logic       force_dma;
    logic       grant_cpu;
    logic       grant_dma;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];

    logic [3:0] starve;

    assign force_dma = dma_req && (starve == STARVE_MAX);

    // Only grants count; DMA waiting through a long CPU access costs one step.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve <= 4'd0;
        end else if (grant_dma) begin
            starve <= 4'd0;
        end else if (grant_cpu && dma_req && (starve < STARVE_MAX)) begin
            starve <= starve + 4'd1;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    assign grant_cpu = (state == IDLE) && cpu_req && !force_dma;
    assign grant_dma = (state == IDLE) && dma_req && (!cpu_req || force_dma);

    assign cpu_stall = cpu_req && !((state == CPU_ACC) && (cnt == WS_LAST));
    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            dma_ack   <= 1'b0;
            dma_rdata <= 16'd0;
        end else begin
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu || grant_dma) begin
                        state     <= grant_cpu ? CPU_ACC : DMA_ACC;
                        cnt       <= 3'd0;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_cpu ? cpu_we    : dma_we;
                        mem_addr  <= grant_cpu ? cpu_addr  : dma_addr;
                        mem_wdata <= grant_cpu ? cpu_wdata : dma_wdata;
                    end
                end
                default: begin
                    if (cnt == WS_LAST) begin
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == DMA_ACC) begin
                            dma_ack <= 1'b1;
                            if (!mem_we) dma_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at WAIT_STATES=1, one at WAIT_STATES=0.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        c_req = 0, c_we = 0;
    logic [15:0] c_addr = 0, c_wdata = 0;
    logic        c_stall;
    logic [15:0] c_rdata;
    logic        d_req = 0, d_we = 0;
    logic [15:0] d_addr = 0, d_wdata = 0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        m_en, m_we;
    logic [15:0] m_addr, m_wdata, m_rdata;

    logic        c1_req = 0;
    logic [15:0] c1_addr = 0;
    logic        c1_stall;
    logic [15:0] c1_rdata;
    logic        d1_ack;
    logic [15:0] d1_rdata;
    logic        m1_en, m1_we;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'd0;

    int n_cmp = 0;
    int n_mis = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    // Memory model: one seeded word, every other address reads its complement.
    assign m_rdata  = (m_addr  == 16'h1234) ? 16'hBEEF : ~m_addr;
    assign m1_rdata = (m1_addr == 16'h1234) ? 16'hBEEF : ~m1_addr;

    always @(posedge clk) if (m_en && m_we) wr_cnt <= wr_cnt + 1;

    mem_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
        .cpu_stall(c_stall), .cpu_rdata(c_rdata),
        .dma_req(d_req), .dma_we(d_we), .dma_addr(d_addr), .dma_wdata(d_wdata),
        .dma_ack(d_ack), .dma_rdata(d_rdata),
        .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata)
    );

    mem_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(3)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(c1_req), .cpu_we(zero1), .cpu_addr(c1_addr), .cpu_wdata(zero16),
        .cpu_stall(c1_stall), .cpu_rdata(c1_rdata),
        .dma_req(zero1), .dma_we(zero1), .dma_addr(zero16), .dma_wdata(zero16),
        .dma_ack(d1_ack), .dma_rdata(d1_rdata),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit exp_dma [8];
        bit got_dma [8];
        int ng;
        logic prev_en;
        int snap;

        // Reset state
        nc(); nc();
        chk("rst_en", m_en, 0);
        chk("rst_we", m_we, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_ack", d_ack, 0);
        chk("rst_drdata", d_rdata, 0);
        chk("rst_stall", c_stall, 0);
        reset = 0;

        // CPU read of 0x1234, WAIT_STATES=1
        @(negedge clk); c_req = 1; c_we = 0; c_addr = 16'h1234; #1;
        chk("crd_c0_stall", c_stall, 1);
        chk("crd_c0_en", m_en, 0);
        nc();
        chk("crd_c1_en", m_en, 1);
        chk("crd_c1_stall", c_stall, 1);
        chk("crd_c1_addr", m_addr, 16'h1234);
        nc();
        chk("crd_c2_en", m_en, 1);
        chk("crd_c2_stall", c_stall, 0);
        chk("crd_c2_rdata", c_rdata, 16'hBEEF);
        c_req = 0;
        nc();
        chk("crd_c3_en", m_en, 0);
        chk("crd_c3_stall", c_stall, 0);

        // DMA write of 0x00AA to 0x8000
        @(negedge clk); d_req = 1; d_we = 1; d_addr = 16'h8000; d_wdata = 16'h00AA; #1;
        chk("dwr_a0_en", m_en, 0);
        nc();
        chk("dwr_a1_en", m_en, 1);
        chk("dwr_a1_we", m_we, 1);
        chk("dwr_a1_addr", m_addr, 16'h8000);
        chk("dwr_a1_wdata", m_wdata, 16'h00AA);
        chk("dwr_a1_ack", d_ack, 0);
        nc();
        chk("dwr_a2_we", m_we, 1);
        chk("dwr_a2_ack", d_ack, 0);
        @(negedge clk); d_req = 0; #1;
        chk("dwr_a3_ack", d_ack, 1);
        chk("dwr_a3_en", m_en, 0);
        chk("dwr_a3_we", m_we, 0);
        chk("dwr_a3_drdata", d_rdata, 0);
        nc();
        chk("dwr_a4_ack", d_ack, 0);

        // CPU request arrives during a DMA read
        @(negedge clk); d_req = 1; d_we = 0; d_addr = 16'h4000; #1;
        @(negedge clk); c_req = 1; c_we = 0; c_addr = 16'h0010; #1;
        chk("mix_b1_stall", c_stall, 1);
        chk("mix_b1_addr", m_addr, 16'h4000);
        nc();
        chk("mix_b2_stall", c_stall, 1);
        chk("mix_b2_en", m_en, 1);
        @(negedge clk); d_req = 0; #1;
        chk("mix_b3_ack", d_ack, 1);
        chk("mix_b3_drdata", d_rdata, 16'hBFFF);
        chk("mix_b3_stall", c_stall, 1);
        chk("mix_b3_en", m_en, 0);
        nc();
        chk("mix_b4_en", m_en, 1);
        chk("mix_b4_addr", m_addr, 16'h0010);
        chk("mix_b4_stall", c_stall, 1);
        chk("mix_b4_ack", d_ack, 0);
        nc();
        chk("mix_b5_stall", c_stall, 0);
        chk("mix_b5_rdata", c_rdata, 16'hFFEF);
        chk("mix_b5_drdata", d_rdata, 16'hBFFF);
        c_req = 0;
        nc();

        // Both requesters held high: record who wins each grant
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_dma = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
        exp_dma = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 16'h0C00;
        d_req = 1; d_we = 0; d_addr = 16'h0D00;
        ng = 0;
        prev_en = 1'b0;
        for (int i = 0; i < 40 && ng < 8; i++) begin
            nc();
            if (m_en && !prev_en) begin
                got_dma[ng] = (m_addr == 16'h0D00);
                ng++;
            end
            prev_en = m_en;
        end
        chk("arb_ngrants", ng, 8);
        for (int i = 0; i < ng; i++) chk($sformatf("arb_grant%0d", i), got_dma[i], exp_dma[i]);
        c_req = 0; d_req = 0;
        repeat (4) nc();

        // Reset on the first access cycle of a CPU write
        @(negedge clk); c_req = 1; c_we = 1; c_addr = 16'h2222; c_wdata = 16'h3333; #1;
        nc();
        chk("rstw_c1_we", m_we, 1);
        reset = 1;
        @(negedge clk); c_req = 0; c_we = 0; #1;
        chk("rstw_en", m_en, 0);
        chk("rstw_we", m_we, 0);
        chk("rstw_ack", d_ack, 0);
        chk("rstw_addr", m_addr, 0);
        chk("rstw_drdata", d_rdata, 0);
        snap = wr_cnt;
        reset = 0;
        repeat (4) nc();
        chk("rstw_nowrite", wr_cnt - snap, 0);
        chk("rstw_idle_en", m_en, 0);

        // WAIT_STATES=0: back-to-back reads of 0x0001 and 0x0002
        @(negedge clk); c1_req = 1; c1_addr = 16'h0001; #1;
        chk("ws0_d0_stall", c1_stall, 1);
        chk("ws0_d0_en", m1_en, 0);
        nc();
        chk("ws0_d1_en", m1_en, 1);
        chk("ws0_d1_stall", c1_stall, 0);
        chk("ws0_d1_rdata", c1_rdata, 16'hFFFE);
        c1_addr = 16'h0002;
        nc();
        chk("ws0_d2_en", m1_en, 0);
        chk("ws0_d2_stall", c1_stall, 1);
        nc();
        chk("ws0_d3_en", m1_en, 1);
        chk("ws0_d3_stall", c1_stall, 0);
        chk("ws0_d3_addr", m1_addr, 16'h0002);
        chk("ws0_d3_rdata", c1_rdata, 16'hFFFD);
        c1_req = 0;
        nc();
        chk("ws0_d4_en", m1_en, 0);
        chk("ws0_d4_stall", c1_stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
